// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared types and constants for the memory bus controller.
//   mem_state_t  : access FSM states (IDLE, REQ, DONE)
//   MEM_ERR_DATA : read data returned when an access is aborted by the ack timer
//   TIMER_W      : width of the ack timeout counter
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [15:0] MEM_ERR_DATA = 16'hFFFF;
    localparam int          TIMER_W      = 8;

endpackage

// File: rtl/mem_bus_ctrl_ack_timer.sv
// mem_ack_timer: counts cycles an access spends waiting for mem_ack.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clear_i : synchronous clear (held while no request is outstanding)
//   en_i    : count enable (one count per waiting cycle)
//   tc_o    : terminal count; high during the LIMIT-th enabled cycle
module mem_ack_timer
    import mem_bus_ctrl_pkg::*;
#(
    parameter int             W     = TIMER_W,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    // count_q holds the number of already-elapsed waiting cycles, so the
    // LIMIT-th waiting cycle is the one where count_q == LIMIT-1.
    assign tc_o = en_i & (count_q == LIMIT - W'(1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges the datapath memory strobes onto a req/ack handshake
// with variable-latency memory and stalls the controlpath until done.
// Optional feature macro: MEM_TIMEOUT_EN (ack timeout + bus_err reporting).
// Ports:
//   clock, reset_L       : clock (rising edge), asynchronous active-low reset
//   cpu_re_L, cpu_we_L   : active-low read / write strobes from controlpath
//   cpu_addr             : access address from datapath
//   dataBus              : shared bus; write data in, read data driven in DONE
//   stall                : hold controlpath while an access is outstanding
//   mem_req/we/addr/wdata: registered request to memory, stable while mem_req
//   mem_rdata, mem_ack   : memory response, rdata sampled with the ack
//   bus_err              : one-cycle pulse on timeout or both strobes (macro only)
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          cpu_re_L,
    input  logic          cpu_we_L,
    input  logic [AW-1:0] cpu_addr,
    inout  wire  [DW-1:0] dataBus,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    mem_state_t    state_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata_q;
    logic          access;
    logic          drive_bus;

    assign access = ~cpu_re_L | ~cpu_we_L;

    // stall rises in the same cycle the strobe appears so the controlpath
    // never advances past an access that has not yet been issued.
    assign stall = (state_q == REQ) | ((state_q == IDLE) & access);

    // Return read data only while a read is strobed and no write strobe is
    // present, so the block never fights the datapath's write driver.
    assign drive_bus = (state_q == DONE) & ~mem_we_q & ~cpu_re_L & cpu_we_L;
    assign dataBus   = drive_bus ? rdata_q : {DW{1'bz}};

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q;
    logic both_low;
    logic timer_tc;

    assign both_low = ~cpu_re_L & ~cpu_we_L;
    assign bus_err  = bus_err_q;

    mem_ack_timer #(
        .W     (TIMER_W),
        .LIMIT (TIMER_W'(ACK_TIMEOUT))
    ) u_ack_timer (
        .clk_i   (clock),
        .rst_ni  (reset_L),
        .clear_i (state_q != REQ),
        .en_i    (state_q == REQ),
        .tc_o    (timer_tc)
    );
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(ACK_TIMEOUT);
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (access) begin
                        mem_addr_q  <= cpu_addr;
                        mem_wdata_q <= dataBus;
                        // Read wins when both strobes are low.
                        mem_we_q    <= ~cpu_we_L & cpu_re_L;
                        mem_req_q   <= 1'b1;
                        state_q     <= REQ;
`ifdef MEM_TIMEOUT_EN
                        bus_err_q   <= both_low;
`endif
                    end
                end
                REQ: begin
                    // An ack arriving on the timeout cycle is a normal completion.
                    if (mem_ack) begin
                        rdata_q   <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timer_tc) begin
                        rdata_q   <= DW'(MEM_ERR_DATA);
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
